// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-burst AXI SRAM slave with FIXED/INCR bursts and round-robin AR/AW arbitration.
// Define AXI_SRAM_SLAVE_WRAP_EN to enable WRAP bursts; otherwise WRAP behaves as INCR.
module axi_sram_slave #(
    parameter int MEM_AW = 12,
    parameter int ID_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [3:0]      arlen,
    input  logic [1:0]      arburst,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [3:0]      awlen,
    input  logic [1:0]      awburst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready
);
    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_e;
    state_e state_q, state_d;
    logic [31:0] mem [2**MEM_AW];
    logic [31:0] rdata_q;
    logic [MEM_AW-1:0] addr_q, addr_d, nxt_idx, rd_idx;
    logic [3:0] len_q, len_d, beat_q, beat_d;
    logic [1:0] burst_q, burst_d;
    logic [ID_W-1:0] id_q, id_d;
    logic err_q, err_d, pref_wr_q, pref_wr_d;
    logic ar_hs, aw_hs, rd_adv, w_hs, rd_en;
    logic unused_addr;

    assign unused_addr = ^{araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0]};
    assign ar_hs  = arready && arvalid;
    assign aw_hs  = awready && awvalid;
    assign rd_adv = rvalid && rready && !rlast;
    assign w_hs   = wready && wvalid;
    assign rd_en  = ar_hs || rd_adv;
    assign rd_idx = ar_hs ? araddr[MEM_AW+1:2] : nxt_idx;

`ifdef AXI_SRAM_SLAVE_WRAP_EN
    logic [MEM_AW-1:0] wmask;
    logic is_wrap;
    // WRAP only for 2/4/8/16-beat bursts: stay inside the aligned (len+1)-word block
    assign wmask   = MEM_AW'(len_q);
    assign is_wrap = burst_q == 2'b10 && len_q != 4'd0 && (len_q & (len_q + 4'd1)) == 4'd0;
    assign nxt_idx = burst_q == 2'b00 ? addr_q :
                     is_wrap ? (addr_q & ~wmask) | ((addr_q + MEM_AW'(1)) & wmask) :
                     addr_q + MEM_AW'(1);
`else
    assign nxt_idx = burst_q == 2'b00 ? addr_q : addr_q + MEM_AW'(1);
`endif

    always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ar_hs ? RD : aw_hs ? WR : IDLE;
            RD:      state_d = rvalid && rready && rlast ? IDLE : RD;
            WR:      state_d = w_hs && beat_q == len_q ? WRESP : WR;
            WRESP:   state_d = bready ? IDLE : WRESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arready = !rst && state_q == IDLE && arvalid && (!awvalid || !pref_wr_q);
        awready = !rst && state_q == IDLE && awvalid && (!arvalid || pref_wr_q);
        rvalid  = state_q == RD;
        rlast   = state_q == RD && beat_q == len_q;
        wready  = !rst && state_q == WR;
        bvalid  = state_q == WRESP;
    end

    always_comb begin
        addr_d    = addr_q;
        len_d     = len_q;
        burst_d   = burst_q;
        id_d      = id_q;
        beat_d    = beat_q;
        err_d     = err_q;
        pref_wr_d = ar_hs ? 1'b1 : aw_hs ? 1'b0 : pref_wr_q;
        if (ar_hs || aw_hs) begin
            addr_d  = ar_hs ? araddr[MEM_AW+1:2] : awaddr[MEM_AW+1:2];
            len_d   = ar_hs ? arlen : awlen;
            burst_d = ar_hs ? arburst : awburst;
            id_d    = ar_hs ? arid : awid;
            beat_d  = 4'd0;
            err_d   = 1'b0;
        end else if (rd_adv || w_hs) begin
            addr_d = nxt_idx;
            beat_d = beat_q + 4'd1;
            err_d  = err_q || (w_hs && (wlast != (beat_q == len_q)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            id_q      <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            pref_wr_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            addr_q    <= addr_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            id_q      <= id_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            pref_wr_q <= pref_wr_d;
            if (rd_en) rdata_q <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (w_hs && wstrb[b]) mem[addr_q][8*b +: 8] <= wdata[8*b +: 8];
    end

    assign rdata = rdata_q;
    assign rid   = id_q;
    assign bid   = id_q;
    assign rresp = 2'b00;
    assign bresp = {err_q, 1'b0};
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: randomized self-checking bench for axi_sram_slave against a word-array reference model.
// Honours AXI_SRAM_SLAVE_WRAP_EN for the expected WRAP addressing.
module tb_axi_sram_slave;
    localparam int ID_W  = 4;
    localparam int DEPTH = 4096;

    logic clk = 1'b0, rst = 1'b1;
    logic [ID_W-1:0] arid = '0, awid = '0, rid, bid;
    logic [31:0] araddr = '0, awaddr = '0, rdata, wdata = '0;
    logic [3:0] arlen = '0, awlen = '0, wstrb = '0;
    logic [1:0] arburst = '0, awburst = '0, rresp, bresp;
    logic arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;
    logic awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready, bvalid, bready = 1'b0;

    int n_cmp = 0, n_bad = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [15:0] wl;
    logic [1:0]  got_resp;
    logic [ID_W-1:0] got_bid, got_rid;
    logic [31:0] rd_q [$];
    int rlast_at, rlast_cnt, stall_bad, extra;
    logic first_rvalid;

    axi_sram_slave #(.MEM_AW(12), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // Word index of beat k, straight from the burst rules
    function automatic int exp_idx(int base, int len, logic [1:0] burst, int k);
        int n = len + 1;
        if (burst == 2'b00) return base;
`ifdef AXI_SRAM_SLAVE_WRAP_EN
        if (burst == 2'b10 && (n == 2 || n == 4 || n == 8 || n == 16)) return (base / n) * n + (base % n + k) % n;
`endif
        return (base + k) % DEPTH;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst, input logic [ID_W-1:0] id);
        int n, idx;
        @(posedge clk); #1;
        awaddr = addr; awlen = len; awburst = burst; awid = id; awvalid = 1'b1; #1;
        n = 0;
        while (!awready && n < 100) begin @(posedge clk); #2; n++; end
        if (!awready) begin n_cmp++; n_bad++; $display("FAIL aw_timeout: awready=%b required 1", awready); end
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wvalid = 1'b1; #1;
            n = 0;
            while (!wready && n < 100) begin @(posedge clk); #2; n++; end
            if (!wready) begin n_cmp++; n_bad++; $display("FAIL w_timeout: wready=%b required 1", wready); end
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1; #1;
        n = 0;
        while (!bvalid && n < 100) begin @(posedge clk); #2; n++; end
        if (!bvalid) begin n_cmp++; n_bad++; $display("FAIL b_timeout: bvalid=%b required 1", bvalid); end
        got_resp = bresp; got_bid = bid;
        @(posedge clk); #1;
        bready = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            idx = exp_idx(int'(addr[13:2]), int'(len), burst, i);
            for (int b = 0; b < 4; b++) if (ws[i][b]) model[idx][8*b +: 8] = wd[i][8*b +: 8];
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst, input logic [ID_W-1:0] id, input bit toggle);
        int n, cyc;
        bit hold, done;
        logic [32:0] held;
        rd_q.delete(); rlast_at = -1; rlast_cnt = 0; stall_bad = 0; extra = 0;
        @(posedge clk); #1;
        araddr = addr; arlen = len; arburst = burst; arid = id; arvalid = 1'b1; #1;
        n = 0;
        while (!arready && n < 100) begin @(posedge clk); #2; n++; end
        if (!arready) begin n_cmp++; n_bad++; $display("FAIL ar_timeout: arready=%b required 1", arready); end
        @(posedge clk); #1;
        arvalid = 1'b0;
        first_rvalid = rvalid;
        cyc = 0; hold = 1'b0; done = 1'b0; held = '0;
        while (cyc < 200 && !done) begin
            rready = toggle ? (cyc % 2 == 0) : 1'b1; #1;
            if (hold && {rlast, rdata} !== held) stall_bad++;
            hold = rvalid && !rready;
            held = {rlast, rdata};
            if (rvalid && rready) begin
                rd_q.push_back(rdata);
                got_rid = rid;
                if (rlast) begin rlast_cnt++; if (rlast_at < 0) rlast_at = rd_q.size(); done = 1'b1; end
            end
            if (!done) begin @(posedge clk); #1; cyc++; end
        end
        if (!done) begin n_cmp++; n_bad++; $display("FAIL r_timeout: rlast handshake missing after %0d cycles, required within 200", cyc); end
        rready = 1'b1;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #2; if (rvalid) extra++; end
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({arready, awready, rvalid, rlast, wready, bvalid} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b required 000000", {arready, awready, rvalid, rlast, wready, bvalid});
        end
        n_cmp++;
        if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h required 00000000", rdata); end
        n_cmp++;
        if ({rid, bid, bresp, rresp} !== '0) begin n_bad++; $display("FAIL reset_ids: got rid=%h bid=%h bresp=%b rresp=%b required all 0", rid, bid, bresp, rresp); end
        rst = 1'b0;
    endtask

    task automatic test_arbitration();
        @(posedge clk); #1;
        araddr = 32'h100; arlen = 4'd0; arburst = 2'b01; arid = 4'h1; arvalid = 1'b1;
        awaddr = 32'h200; awlen = 4'd0; awburst = 2'b01; awid = 4'h2; awvalid = 1'b1; #1;
        n_cmp++;
        if ({arready, awready} !== 2'b10) begin n_bad++; $display("FAIL arb_first: got ar/aw ready %b required 10", {arready, awready}); end
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1; #1;
        n_cmp++;
        if ({rvalid, rid, awready} !== {1'b1, 4'h1, 1'b0}) begin
            n_bad++; $display("FAIL arb_read_beat: got rvalid=%b rid=%h awready=%b required 1 1 0", rvalid, rid, awready);
        end
        @(posedge clk); #1;
        rready = 1'b0; arvalid = 1'b1; #1;
        n_cmp++;
        if ({arready, awready} !== 2'b01) begin n_bad++; $display("FAIL arb_second: got ar/aw ready %b required 01", {arready, awready}); end
        @(posedge clk); #1;
        awvalid = 1'b0; arvalid = 1'b0;
        wdata = 32'hCAFE0001; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1; #1;
        n_cmp++;
        if (wready !== 1'b1) begin n_bad++; $display("FAIL arb_wready: got %b required 1", wready); end
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1; #1;
        n_cmp++;
        if ({bvalid, bid, bresp} !== {1'b1, 4'h2, 2'b00}) begin
            n_bad++; $display("FAIL arb_bresp: got bvalid=%b bid=%h bresp=%b required 1 2 00", bvalid, bid, bresp);
        end
        @(posedge clk); #1;
        bready = 1'b0;
        model[12'h080] = 32'hCAFE0001;
    endtask

    task automatic test_incr();
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(32'hA0 + i); ws[i] = 4'hF; end
        wl = 16'h0008;
        do_write(32'h100, 4'd3, 2'b01, 4'h5);
        n_cmp++;
        if ({got_resp, got_bid} !== {2'b00, 4'h5}) begin n_bad++; $display("FAIL incr_bresp: got bresp=%b bid=%h required 00 5", got_resp, got_bid); end
        do_read(32'h100, 4'd3, 2'b01, 4'h6, 1'b0);
        n_cmp++;
        if (first_rvalid !== 1'b1) begin n_bad++; $display("FAIL incr_latency: rvalid one cycle after AR got %b required 1", first_rvalid); end
        n_cmp++;
        if (rd_q.size() != 4 || rlast_at != 4 || rlast_cnt != 1 || extra != 0) begin
            n_bad++; $display("FAIL incr_beats: got beats=%0d rlast_at=%0d rlasts=%0d extra=%0d required 4 4 1 0", rd_q.size(), rlast_at, rlast_cnt, extra);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (rd_q[k] !== 32'(32'hA0 + k)) begin n_bad++; $display("FAIL incr_data[%0d]: got %h required %h", k, rd_q[k], 32'(32'hA0 + k)); end
        end
        n_cmp++;
        if (got_rid !== 4'h6) begin n_bad++; $display("FAIL incr_rid: got %h required 6", got_rid); end
    endtask

    task automatic test_strobe();
        wd[0] = 32'h11223344; ws[0] = 4'hF; wl = 16'h0001;
        do_write(32'h400, 4'd0, 2'b01, 4'h3);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(32'h400, 4'd0, 2'b01, 4'h3);
        do_read(32'h400, 4'd0, 2'b01, 4'h3, 1'b0);
        n_cmp++;
        if (rd_q[0] !== 32'h11BB33DD) begin n_bad++; $display("FAIL strobe_merge: got %h required 11BB33DD", rd_q[0]); end
        wd[0] = $urandom; ws[0] = 4'($urandom);
        do_write(32'h400, 4'd0, 2'b01, 4'h3);
        do_read(32'h400, 4'd0, 2'b01, 4'h3, 1'b0);
        n_cmp++;
        if (rd_q[0] !== model[12'h100]) begin n_bad++; $display("FAIL strobe_random: got %h required %h", rd_q[0], model[12'h100]); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        wl = 16'h0080;
        do_write(32'h500, 4'd7, 2'b01, 4'h7);
        do_read(32'h500, 4'd7, 2'b01, 4'h9, 1'b1);
        n_cmp++;
        if (rd_q.size() != 8 || rlast_at != 8 || rlast_cnt != 1 || extra != 0) begin
            n_bad++; $display("FAIL stall_beats: got beats=%0d rlast_at=%0d rlasts=%0d extra=%0d required 8 8 1 0", rd_q.size(), rlast_at, rlast_cnt, extra);
        end
        n_cmp++;
        if (stall_bad != 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes during stalls required 0", stall_bad); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (rd_q[k] !== model[12'h140 + k]) begin n_bad++; $display("FAIL stall_data[%0d]: got %h required %h", k, rd_q[k], model[12'h140 + k]); end
        end
    endtask

    task automatic test_burst_types();
        int exp_w [4];
        for (int i = 0; i < 8; i++) begin wd[i] = 32'(32'hC0DE0000 + 32'h0C + i); ws[i] = 4'hF; end
        wl = 16'h0080;
        do_write(32'h30, 4'd7, 2'b01, 4'h1);
`ifdef AXI_SRAM_SLAVE_WRAP_EN
        exp_w = '{32'h0E, 32'h0F, 32'h0C, 32'h0D};
`else
        exp_w = '{32'h0E, 32'h0F, 32'h10, 32'h11};
`endif
        do_read(32'h38, 4'd3, 2'b10, 4'h2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (rd_q[k] !== 32'(32'hC0DE0000 + exp_w[k])) begin
                n_bad++; $display("FAIL wrap_data[%0d]: got %h required %h", k, rd_q[k], 32'(32'hC0DE0000 + exp_w[k]));
            end
        end
        do_read(32'h34, 4'd2, 2'b00, 4'h2, 1'b0);
        n_cmp++;
        if (rd_q.size() != 3 || rd_q[0] !== 32'hC0DE000D || rd_q[2] !== 32'hC0DE000D) begin
            n_bad++; $display("FAIL fixed_read: got beats=%0d first=%h last=%h required 3 C0DE000D C0DE000D", rd_q.size(), rd_q[0], rd_q[2]);
        end
    endtask

    task automatic test_slverr();
        logic [1:0] pat [3] = '{2'b11, 2'b00, 2'b10};
        logic [1:0] exp [3] = '{2'b10, 2'b10, 2'b00};
        for (int t = 0; t < 3; t++) begin
            wd[0] = $urandom; wd[1] = $urandom; ws[0] = 4'hF; ws[1] = 4'hF; wl = {14'd0, pat[t]};
            do_write(32'h600, 4'd1, 2'b01, 4'(t + 8));
            n_cmp++;
            if ({got_resp, got_bid} !== {exp[t], 4'(t + 8)}) begin
                n_bad++; $display("FAIL slverr[%0d]: got bresp=%b bid=%h required %b %h", t, got_resp, got_bid, exp[t], 4'(t + 8));
            end
        end
        do_read(32'h600, 4'd1, 2'b01, 4'h0, 1'b0);
        n_cmp++;
        if (rd_q[0] !== model[12'h180] || rd_q[1] !== model[12'h181]) begin
            n_bad++; $display("FAIL slverr_data: got %h %h required %h %h", rd_q[0], rd_q[1], model[12'h180], model[12'h181]);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        araddr = 32'h500; arlen = 4'd3; arburst = 2'b01; arid = 4'h4; arvalid = 1'b1; rready = 1'b1; #1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({rvalid, rlast} !== 2'b10) begin n_bad++; $display("FAIL mid_beat2: got rvalid/rlast %b required 10", {rvalid, rlast}); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (rvalid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rvalid: got %b required 0", rvalid); end
        rst = 1'b0; rready = 1'b0; arvalid = 1'b1; #1;
        n_cmp++;
        if (arready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_arready: got %b required 1", arready); end
        arvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (rvalid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_no_beats: got rvalid=%b required 0", rvalid); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int len, base, idx;
        logic [1:0] bu;
        logic [ID_W-1:0] id;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 16; j++) begin wd[j] = $urandom; ws[j] = 4'hF; end
            wl = 16'h8000;
            do_write(32'(32'hC00 + i * 64), 4'd15, 2'b01, 4'h0);
        end
        for (int it = 0; it < 30; it++) begin
            len = $urandom_range(0, 15);
            bu = 2'($urandom_range(0, 3));
            id = 4'($urandom);
            base = $urandom_range(0, 63 - len);
            a = {18'($urandom), 12'(12'h300 + base), 2'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < 16; j++) begin wd[j] = $urandom; ws[j] = 4'($urandom); end
                wl = 16'(16'd1 << len);
                do_write(a, 4'(len), bu, id);
                n_cmp++;
                if ({got_resp, got_bid} !== {2'b00, id}) begin
                    n_bad++; $display("FAIL rnd_write[%0d]: got bresp=%b bid=%h required 00 %h", it, got_resp, got_bid, id);
                end
            end else begin
                do_read(a, 4'(len), bu, id, 1'($urandom_range(0, 1)));
                n_cmp++;
                if (rd_q.size() != len + 1 || rlast_at != len + 1 || got_rid !== id || stall_bad != 0 || extra != 0) begin
                    n_bad++; $display("FAIL rnd_read_ctl[%0d]: got beats=%0d rlast_at=%0d rid=%h stalls=%0d extra=%0d required %0d %0d %h 0 0",
                                      it, rd_q.size(), rlast_at, got_rid, stall_bad, extra, len + 1, len + 1, id);
                end
                for (int k = 0; k <= len; k++) begin
                    idx = exp_idx(12'h300 + base, len, bu, k);
                    n_cmp++;
                    if (rd_q[k] !== model[idx]) begin
                        n_bad++; $display("FAIL rnd_read_data[%0d.%0d]: got %h required %h (word %h)", it, k, rd_q[k], model[idx], idx);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_incr();
        test_strobe();
        test_stall();
        test_burst_types();
        test_slverr();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
